// File: rtl/riscv_v_inst_queue.sv
// Purpose : OP-V instruction FIFO in front of vector decode. Non-OP-V instructions are accepted but dropped.
// Latency : 1 cycle from push edge to visibility at the head. There is no bypass path.
// Backpr. : in_ready = !full. A decode stall holds the head. clear_pipe flushes the queue synchronously.
//
// Ports:
//   clk, rst (async active-low), clear_pipe (sync flush)
//   in_valid / in_instruction / in_ready : front-end handshake
//   stall                                : decode stall, head not consumed
//   instruction_id / inst_valid_id       : head entry (NOP_INST when empty)
//   count / full / empty                 : occupancy status
module riscv_v_inst_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_pipe,
  input  logic                       in_valid,
  input  logic [31:0]                in_instruction,
  output logic                       in_ready,
  input  logic                       stall,
  output logic [31:0]                instruction_id,
  output logic                       inst_valid_id,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [6:0]  OPC_OP_V = 7'b1010111;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign in_ready = !full;

  // Handshake completes for any instruction; only OP-V instructions are stored.
  assign push = in_valid && in_ready && (in_instruction[6:0] == OPC_OP_V) && !clear_pipe;
  assign pop  = inst_valid_id && !stall && !clear_pipe;

  assign inst_valid_id  = !empty;
  assign instruction_id = empty ? NOP_INST : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear_pipe) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instruction;
  end

  a_count_max:   assert property (@(posedge clk) disable iff (!rst) count <= DEPTH_C);
  a_full_empty:  assert property (@(posedge clk) disable iff (!rst) !(full && empty));
  a_no_push_ful: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_riscv_v_inst_queue.sv
// Purpose : Directed table-driven bench for riscv_v_inst_queue, plus flush and async-reset sequences.
// Latency : Each vector is driven at the negedge. The resulting state is checked 1 time unit after the next posedge.
// Backpr. : Not applicable; the bench drives in_valid and stall directly.
module tb_riscv_v_inst_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_pipe;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic        in_ready;
  logic        stall;
  logic [31:0] instruction_id;
  logic        inst_valid_id;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_v_inst_queue #(.DEPTH(4), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear_pipe     (clear_pipe),
    .in_valid       (in_valid),
    .in_instruction (in_instruction),
    .in_ready       (in_ready),
    .stall          (stall),
    .instruction_id (instruction_id),
    .inst_valid_id  (inst_valid_id),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        st;
    logic        clr;
    logic [2:0]  cnt;
    logic [31:0] id;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [31:0] ins, input logic st, input logic clr,
                     input logic [2:0] cnt, input logic [31:0] id);
    vec_t e;
    e.v = v; e.ins = ins; e.st = st; e.clr = clr; e.cnt = cnt; e.id = id;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Occupancy flags follow directly from the expected count.
  task automatic check_state(input string tag, input logic [2:0] cnt, input logic [31:0] id);
    chk({tag, ".count"},    32'(count),          32'(cnt));
    chk({tag, ".empty"},    32'(empty),          32'(cnt == 3'd0));
    chk({tag, ".full"},     32'(full),           32'(cnt == 3'd4));
    chk({tag, ".in_ready"}, 32'(in_ready),       32'(cnt != 3'd4));
    chk({tag, ".valid"},    32'(inst_valid_id),  32'(cnt != 3'd0));
    chk({tag, ".id"},       instruction_id,      id);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic clr);
    @(negedge clk);
    in_valid = v; in_instruction = ins; stall = st; clear_pipe = clr;
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic st,
                      input logic clr, input logic [2:0] cnt, input logic [31:0] id);
    drive(v, ins, st, clr);
    @(posedge clk);
    #1;
    check_state(tag, cnt, id);
  endtask

  localparam logic [31:0] A = 32'h0220_8057, B = 32'h0220_C057, C = 32'h0221_0057;

  initial begin
    rst = 1'b0; clear_pipe = 1'b0; in_valid = 1'b0; in_instruction = '0; stall = 1'b0;

    // Test 1: three OP-V pushes with no stall, each popped on the following cycle.
    add(1, A, 0, 0, 1, A);
    add(1, B, 0, 0, 1, B);
    add(1, C, 0, 0, 1, C);
    add(0, 0, 0, 0, 0, NOP);
    // Test 3: non-OP-V instructions are accepted but not stored.
    add(1, 32'h0000_0013, 0, 0, 0, NOP);
    add(1, 32'h0000_0033, 0, 0, 0, NOP);
    // Test 2: fill while stalled; the 5th is held until full drops.
    add(1, 32'h0000_A057, 1, 0, 1, 32'h0000_A057);
    add(1, 32'h0000_B057, 1, 0, 2, 32'h0000_A057);
    add(1, 32'h0000_C057, 1, 0, 3, 32'h0000_A057);
    add(1, 32'h0000_D057, 1, 0, 4, 32'h0000_A057);
    add(1, 32'h0000_E057, 1, 0, 4, 32'h0000_A057);
    add(1, 32'h0000_E057, 0, 0, 3, 32'h0000_B057);   // full: pop only
    add(1, 32'h0000_E057, 0, 0, 3, 32'h0000_C057);   // push E with pop
    add(0, 0, 0, 0, 2, 32'h0000_D057);
    add(0, 0, 0, 0, 1, 32'h0000_E057);
    add(0, 0, 0, 0, 0, NOP);
    // Test 4: count=2, then 6 cycles of simultaneous push and pop.
    add(1, 32'h0000_1057, 1, 0, 1, 32'h0000_1057);
    add(1, 32'h0000_2057, 1, 0, 2, 32'h0000_1057);
    add(1, 32'h0000_3057, 0, 0, 2, 32'h0000_2057);
    add(1, 32'h0000_4057, 0, 0, 2, 32'h0000_3057);
    add(1, 32'h0000_5057, 0, 0, 2, 32'h0000_4057);
    add(1, 32'h0000_6057, 0, 0, 2, 32'h0000_5057);
    add(1, 32'h0000_7057, 0, 0, 2, 32'h0000_6057);
    add(1, 32'h0000_8057, 0, 0, 2, 32'h0000_7057);
    add(0, 0, 0, 0, 1, 32'h0000_8057);
    add(0, 0, 0, 0, 0, NOP);

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    check_state("reset", 3'd0, NOP);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].ins, tbl[i].st, tbl[i].clr, tbl[i].cnt, tbl[i].id);

    // Test 5: flush with a push in flight at count=3.
    step("t5.f1", 1, 32'h0001_1057, 1, 0, 1, 32'h0001_1057);
    step("t5.f2", 1, 32'h0001_2057, 1, 0, 2, 32'h0001_1057);
    step("t5.f3", 1, 32'h0001_3057, 1, 0, 3, 32'h0001_1057);
    drive(1, 32'h0001_4057, 0, 1);
    #1;
    chk("t5.in_ready_flush", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_state("t5.flushed", 3'd0, NOP);
    step("t5.idle", 0, 0, 0, 0, 0, NOP);
    step("t5.push", 1, 32'h0001_5057, 1, 0, 1, 32'h0001_5057);
    step("t5.pop",  0, 0, 0, 0, 0, NOP);

    // Test 6: asynchronous reset mid-stream with count=3.
    step("t6.f1", 1, 32'h0002_1057, 1, 0, 1, 32'h0002_1057);
    step("t6.f2", 1, 32'h0002_2057, 1, 0, 2, 32'h0002_1057);
    step("t6.f3", 1, 32'h0002_3057, 1, 0, 3, 32'h0002_1057);
    drive(0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    check_state("t6.async", 3'd0, NOP);
    @(negedge clk); rst = 1'b1;
    step("t6.after", 0, 0, 0, 0, 0, NOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
